// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: registered one-hot grant, one dead turnaround
// cycle on every handoff, and a watchdog that revokes over-long tenures.
module bus_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 8
) (
    input  logic               BUS_CLK,
    input  logic               RST,
    input  logic [NUM_REQ-1:0] BR,
    output logic [NUM_REQ-1:0] BG,
    output logic               BUS_BUSY,
    output logic [ID_W-1:0]    GRANT_ID,
    output logic               TIMEOUT
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] TURN  = 2'd2;

    localparam int TO_LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;

    logic [1:0]       state;
    logic [ID_W-1:0]  owner;
    logic [ID_W-1:0]  last;
    logic [CNT_W-1:0] cnt;

    logic             found;
    logic [ID_W-1:0]  winner;
    logic [ID_W-1:0]  idx;

    // Scan starts just past the most recent owner, so it ends up lowest priority.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ID_W'((int'(last) + 1 + i) % NUM_REQ);
            if (!found && BR[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            state    <= IDLE;
            owner    <= '0;
            last     <= ID_W'(NUM_REQ - 1);
            cnt      <= '0;
            BG       <= '0;
            BUS_BUSY <= 1'b0;
            GRANT_ID <= '0;
            TIMEOUT  <= 1'b0;
        end else begin
            TIMEOUT <= 1'b0;
            case (state)
                GRANT: begin
                    if (!BR[owner]) begin
                        state    <= TURN;
                        BG       <= '0;
                        BUS_BUSY <= 1'b0;
                    end else if ((TIMEOUT_CYC != 0) && (cnt == CNT_W'(TO_LAST))) begin
                        state    <= TURN;
                        BG       <= '0;
                        BUS_BUSY <= 1'b0;
                        TIMEOUT  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                // IDLE and TURN both hand the bus to the next winner, if any.
                default: begin
                    if (found) begin
                        state    <= GRANT;
                        owner    <= winner;
                        last     <= winner;
                        cnt      <= '0;
                        BG       <= NUM_REQ'(1) << winner;
                        BUS_BUSY <= 1'b1;
                        GRANT_ID <= winner;
                    end else begin
                        state    <= IDLE;
                        BG       <= '0;
                        BUS_BUSY <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: one instance with a 16-cycle watchdog and
// one with the watchdog disabled, both driven by the same request lines.
module tb_bus_arbiter;

    logic       bus_clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] br = 4'b0000;

    logic [3:0] bg;
    logic       bus_busy;
    logic [1:0] grant_id;
    logic       timeout;

    logic [3:0] bg0;
    logic       bus_busy0;
    logic [1:0] grant_id0;
    logic       timeout0;

    int check_count = 0;
    int pass_count  = 0;

    typedef struct {
        string      tag;
        logic [3:0] bg;
        logic [1:0] gid;
        logic       to;
        logic [3:0] bg0;
        logic [1:0] gid0;
        logic       to0;
    } exp_t;

    exp_t exp_q[$];

    bus_arbiter #(.NUM_REQ(4), .ID_W(2), .TIMEOUT_CYC(16), .CNT_W(8)) dut (
        .BUS_CLK (bus_clk),
        .RST     (rst),
        .BR      (br),
        .BG      (bg),
        .BUS_BUSY(bus_busy),
        .GRANT_ID(grant_id),
        .TIMEOUT (timeout)
    );

    bus_arbiter #(.NUM_REQ(4), .ID_W(2), .TIMEOUT_CYC(0), .CNT_W(8)) dut_nowd (
        .BUS_CLK (bus_clk),
        .RST     (rst),
        .BR      (br),
        .BG      (bg0),
        .BUS_BUSY(bus_busy0),
        .GRANT_ID(grant_id0),
        .TIMEOUT (timeout0)
    );

    always #5 bus_clk = ~bus_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed === expected)
            pass_count++;
        else
            $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
    endtask

    // Drives one cycle of inputs and queues what both instances must show after the edge.
    task automatic applyStimulus(input logic r, input logic [3:0] b,
                                 input logic [3:0] ebg, input logic [1:0] egid, input logic eto,
                                 input logic [3:0] ebg0, input logic [1:0] egid0, input logic eto0,
                                 input string tag);
        exp_t e;
        @(negedge bus_clk);
        rst = r;
        br  = b;
        e.tag  = tag;
        e.bg   = ebg;
        e.gid  = egid;
        e.to   = eto;
        e.bg0  = ebg0;
        e.gid0 = egid0;
        e.to0  = eto0;
        exp_q.push_back(e);
    endtask

    task automatic applySame(input logic r, input logic [3:0] b, input logic [3:0] ebg,
                             input logic [1:0] egid, input logic eto, input string tag);
        applyStimulus(r, b, ebg, egid, eto, ebg, egid, eto, tag);
    endtask

    always begin
        exp_t e;
        @(posedge bus_clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput({e.tag, ".bg"},    32'(bg),        32'(e.bg));
            checkOutput({e.tag, ".busy"},  32'(bus_busy),  32'(|e.bg));
            checkOutput({e.tag, ".gid"},   32'(grant_id),  32'(e.gid));
            checkOutput({e.tag, ".to"},    32'(timeout),   32'(e.to));
            checkOutput({e.tag, ".bg0"},   32'(bg0),       32'(e.bg0));
            checkOutput({e.tag, ".busy0"}, 32'(bus_busy0), 32'(|e.bg0));
            checkOutput({e.tag, ".gid0"},  32'(grant_id0), 32'(e.gid0));
            checkOutput({e.tag, ".to0"},   32'(timeout0),  32'(e.to0));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running, want finished");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        logic [3:0] oh;
        logic [3:0] rel;
        int w;
        int p;

        // Reset held with every line requesting, then requester 0 wins first.
        for (int i = 0; i < 3; i++) applySame(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, "rst_hold");
        applySame(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b0, "rst_first");
        applySame(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "rst_turn");
        applySame(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "rst_idle");

        for (int i = 0; i < 5; i++) applySame(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b0, "single");
        applySame(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, "single_turn");
        applySame(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, "single_idle");

        for (int i = 0; i < 3; i++) applySame(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b0, "simul_g0");
        applySame(1'b0, 4'b0010, 4'b0000, 2'd0, 1'b0, "simul_turn0");
        for (int i = 0; i < 3; i++) applySame(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b0, "simul_g1");
        applySame(1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0, "simul_turn1");
        applySame(1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0, "simul_idle");

        applySame(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, "rr_rst");
        for (int k = 0; k < 6; k++) begin
            w   = k % 4;
            oh  = 4'b0001 << w;
            rel = (k == 5) ? 4'b0000 : (4'b1111 & ~oh);
            applySame(1'b0, 4'b1111, oh, 2'(w), 1'b0, "rr_grant");
            applySame(1'b0, 4'b1111, oh, 2'(w), 1'b0, "rr_hold");
            applySame(1'b0, rel, 4'b0000, 2'(w), 1'b0, "rr_turn");
        end
        applySame(1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0, "rr_idle");

        // Watchdog instance cycles 16 grant + 1 revoke; the disabled one holds throughout.
        for (int e = 1; e <= 40; e++) begin
            p = (e - 1) % 17;
            if (p < 16)
                applyStimulus(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b0, 4'b0010, 2'd1, 1'b0, "wd_grant");
            else
                applyStimulus(1'b0, 4'b0010, 4'b0000, 2'd1, 1'b1, 4'b0010, 2'd1, 1'b0, "wd_revoke");
        end
        applySame(1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0, "wd_release");
        applySame(1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0, "wd_idle");

        for (int i = 0; i < 16; i++) applySame(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b0, "race_grant");
        applySame(1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0, "race_release");
        applySame(1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0, "race_idle");

        applySame(1'b0, 4'b1000, 4'b1000, 2'd3, 1'b0, "mid_grant");
        applySame(1'b0, 4'b1000, 4'b1000, 2'd3, 1'b0, "mid_hold");
        applySame(1'b1, 4'b1000, 4'b0000, 2'd0, 1'b0, "mid_rst");
        applySame(1'b0, 4'b1001, 4'b0001, 2'd0, 1'b0, "mid_g0");
        applySame(1'b0, 4'b1001, 4'b0001, 2'd0, 1'b0, "mid_h0");
        applySame(1'b0, 4'b1000, 4'b0000, 2'd0, 1'b0, "mid_turn0");
        applySame(1'b0, 4'b1000, 4'b1000, 2'd3, 1'b0, "mid_g3");
        applySame(1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0, "mid_turn3");
        applySame(1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0, "mid_idle");

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge bus_clk);
        if (exp_q.size() != 0) checkOutput("drain", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
